pipe_adder: RTL and testbench
=============================

Name: pipe_adder

Overview:
- Parametrised, pipelined add/subtract unit. It is the next generation of the team's 16-bit ripple-carry adder.
- The WIDTH-bit operation is split into STAGES equal chunks. Each pipeline stage adds one chunk and registers the carry into the next stage.
- Input and output both use valid/ready handshakes. The unit accepts one operation per cycle.
- Used wherever wide arithmetic must meet timing that a single long ripple chain cannot.

Parameters:
- WIDTH, 32, operand and result width in bits. WIDTH % STAGES must be 0; elaboration fails otherwise.
- STAGES, 4, number of pipeline stages, 1..WIDTH.
- CHUNK, WIDTH/STAGES, bits added per stage (localparam, not overridable).

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  operation presented
- in_ready  output  1  unit can accept this cycle
- in1  input  WIDTH  operand A
- in2  input  WIDTH  operand B
- cin  input  1  carry in; ignored when sub=1
- sub  input  1  0: A+B+cin; 1: A−B (A + ~B + 1)
- out_valid  output  1  result presented
- out_ready  input  1  consumer accepts the result
- sum  output  WIDTH  result
- cout  output  1  carry out of the MSB (for sub: 1 = no borrow)
- ovf  output  1  two's-complement signed overflow

Behaviour:
- Reset: asynchronous on rst_n low; all stage valid bits clear. Required output values while in reset: out_valid=0, sum=0, cout=0, ovf=0, in_ready=1.
- Reset mid-operation: all in-flight operations are discarded. Nothing is emitted after reset releases.
- Operand preprocessing at the input:
  - B' = sub ? ~in2 : in2.
  - c0 = sub ? 1 : cin.
- Stage k (0..STAGES-1):
  - Adds bits [k*CHUNK +: CHUNK] of A and B' with the incoming carry.
  - Registers the chunk sum, the carry out, the not-yet-added upper operand bits, and the completed lower sum bits.
  - The last stage also captures ovf = carry-into-MSB XOR carry-out-of-MSB.
- Handshake:
  - A transfer occurs when valid and ready are both 1 on a rising edge. This holds at both input and output.
  - adv[STAGES-1] = out_valid & out_ready.
  - adv[k] = v[k] & (!v[k+1] | adv[k+1]).
  - in_ready = !v[0] | adv[0]. This is a combinational path from out_ready, which is permitted.
  - A stage captures new data when the previous stage advances. Its valid bit clears when it advances and nothing arrives.
- Latency and throughput:
  - Latency: an operation accepted at edge N presents out_valid after edge N+STAGES-1, i.e. in the cycle following that edge. With STAGES=1 it is registered once.
  - Throughput: one operation per cycle when out_ready stays high. There are no bubbles.
- Backpressure:
  - While out_valid=1 and out_ready=0, sum, cout and ovf hold stable.
  - Stages fill up behind the stalled output. Once every stage is valid, in_ready drops to 0.
  - Ordering is strictly FIFO. No operation is dropped or duplicated.
- Simultaneous events: a full pipeline with out_ready=1 and in_valid=1 accepts and emits in the same cycle.
- Width rules:
  - Carry between chunks is exactly 1 bit.
  - sum wraps modulo 2^WIDTH.
  - For sub, ovf is set when signs differ and the result sign differs from A.
- in1, in2, cin and sub are sampled only on accepted transfers. Input changes while in_ready=0 have no effect.

Decomposition:
- No shared package is needed; CHUNK is a local constant.
- One sub-module, pipe_adder_stage (parameter CHUNK):
  - Chunk adder with carry in and out.
  - Internally a ripple chain of the existing full_adder cells, or behavioural +.
  - Instantiated STAGES times through a generate loop.
- Top level holds the handshake logic, valid bits and operand/partial-sum registers.

Test Plan:
- Defaults (WIDTH=32, STAGES=4). Single op A=FFFFFFFF, B=00000001, cin=0, sub=0 -> after 4 edges: sum=00000000, cout=1, ovf=0, out_valid=1 for one cycle with out_ready=1.
- Signed overflow. A=7FFFFFFF, B=00000001 -> sum=80000000, cout=0, ovf=1. Then A=80000000, B=80000000 -> sum=0, cout=1, ovf=1.
- Subtract, with cin=1 to confirm it is ignored:
  - 7−5 -> sum=00000002, cout=1, ovf=0.
  - 5−7 -> sum=FFFFFFFE, cout=0, ovf=0.
  - 80000000−1 -> sum=7FFFFFFF, ovf=1.
- Backpressure. Stream 10 ops back-to-back, out_ready=0 for cycles 3..8 -> in_ready falls after 4 ops are held. Output stays frozen during the stall. All 10 results emerge in order, matching the reference model.
- Reset. Assert rst_n=0 asynchronously mid-stream with 3 ops in flight -> out_valid=0, sum=0, cout=0, ovf=0 immediately, in_ready=1. No stale results appear after release.
- Parameter sweep. Random traffic with random out_ready at (WIDTH,STAGES) = (16,1), (16,16), (64,8) -> every result equals the {cout,sum} model, ovf is correct, and latency equals STAGES.

Source files
------------

// File: rtl/pipe_adder_stage.sv
// One chunk of the pipelined adder: a CHUNK-bit add with a 1-bit carry in and
// a 1-bit carry out. The register that holds the result lives in the top level.
module pipe_adder_stage #(
  parameter int CHUNK = 8
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co
);

  assign {co, s} = {1'b0, a} + {1'b0, b} + (CHUNK + 1)'(ci);

endmodule

// File: rtl/pipe_adder.sv
// Pipelined WIDTH-bit add/subtract unit. Each of STAGES stages adds one chunk and
// registers its carry, with valid/ready handshakes at both ends.
module pipe_adder #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int CHUNK = WIDTH / STAGES;
  localparam int LAST  = STAGES - 1;

  if (STAGES < 1 || STAGES > WIDTH || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipe_adder: WIDTH must be a multiple of STAGES and STAGES in 1..WIDTH");
  end

  logic [STAGES-1:0] v;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] cap;
  logic              free_above;

  logic [WIDTH-1:0]  a_q    [STAGES];
  logic [WIDTH-1:0]  b_q    [STAGES];
  logic [WIDTH-1:0]  s_q    [STAGES];
  logic [STAGES-1:0] c_q;
  logic              ovf_q;

  logic [WIDTH-1:0]  a_src  [STAGES];
  logic [WIDTH-1:0]  b_src  [STAGES];
  logic [STAGES-1:0] c_src;
  logic [WIDTH-1:0]  s_next [STAGES];
  logic [CHUNK-1:0]  chunk_s [STAGES];
  logic [STAGES-1:0] chunk_co;
  logic              ovf_next;

  // Walk from the output back to the input: a stage may move when the stage
  // downstream is empty or is itself moving this cycle.
  always_comb begin
    adv        = '0;
    cap        = '0;
    // NOTE: free_above is a running value inside the loop, so blocking '=' is
    // required here; every variable gets its default before the loop.
    free_above = out_ready;
    for (int k = LAST; k >= 0; k--) begin
      adv[k]     = v[k] & free_above;
      free_above = ~v[k] | free_above;
    end
    in_ready = free_above;
    cap[0]   = in_valid & free_above;
    for (int k = 1; k < STAGES; k++) begin
      cap[k] = adv[k-1];
    end
  end

  // Operands feeding each chunk adder; B is inverted once at the input for sub.
  always_comb begin
    a_src    = a_q;
    b_src    = b_q;
    c_src    = '0;
    a_src[0] = in1;
    b_src[0] = sub ? ~in2 : in2;
    c_src[0] = sub | cin;
    for (int k = 1; k < STAGES; k++) begin
      a_src[k] = a_q[k-1];
      b_src[k] = b_q[k-1];
      c_src[k] = c_q[k-1];
    end
  end

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    pipe_adder_stage #(.CHUNK(CHUNK)) u_stage (
      .a  (a_src[k][k*CHUNK +: CHUNK]),
      .b  (b_src[k][k*CHUNK +: CHUNK]),
      .ci (c_src[k]),
      .s  (chunk_s[k]),
      .co (chunk_co[k])
    );
  end

  // Completed lower bits travel with the operation; each stage fills in its chunk.
  always_comb begin
    s_next    = s_q;
    s_next[0] = '0;
    for (int k = 1; k < STAGES; k++) begin
      s_next[k] = s_q[k-1];
    end
    for (int k = 0; k < STAGES; k++) begin
      s_next[k][k*CHUNK +: CHUNK] = chunk_s[k];
    end
    ovf_next = (a_src[LAST][WIDTH-1] == b_src[LAST][WIDTH-1]) &
               (s_next[LAST][WIDTH-1] != a_src[LAST][WIDTH-1]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the data registers are reset as well as the valid bits, because
      // sum/cout/ovf must read zero while reset is held.
      v     <= '0;
      c_q   <= '0;
      ovf_q <= 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (cap[k]) begin
          v[k]   <= 1'b1;
          a_q[k] <= a_src[k];
          b_q[k] <= b_src[k];
          s_q[k] <= s_next[k];
          c_q[k] <= chunk_co[k];
        end else if (adv[k]) begin
          v[k] <= 1'b0;
        end
      end
      if (cap[LAST]) begin
        ovf_q <= ovf_next;
      end
    end
  end

  assign out_valid = v[LAST];
  assign sum       = s_q[LAST];
  assign cout      = c_q[LAST];
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Self-checking bench for pipe_adder: directed vectors, backpressure and reset
// sequences on the default build, plus random traffic on three other shapes.
module tb_pipe_adder;

  localparam int W    = 32;
  localparam int S    = 4;
  localparam int NOPS = 60;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, rst_s;
  logic          in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [W-1:0]  in1, in2, sum;

  int n_cmp      = 0;
  int n_fail     = 0;
  int cycle      = 0;
  int sweep_done = 0;

  always @(posedge clk) cycle <= cycle + 1;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic [31:0] e_sum;
    logic        e_cout;
    logic        e_ovf;
    string       name;
  } vec_t;

  pipe_adder #(.WIDTH(W), .STAGES(S)) u_dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference {ovf, cout, sum} for the 32-bit build.
  function automatic logic [33:0] model(input logic [31:0] a, input logic [31:0] b,
                                        input logic c, input logic sb);
    logic [31:0] bb;
    logic [32:0] r;
    bb = sb ? ~b : b;
    r  = {1'b0, a} + {1'b0, bb} + 33'(sb | c);
    return {(a[31] == bb[31]) && (r[31] != a[31]), r};
  endfunction

  task automatic run_single(input vec_t v);
    @(negedge clk);
    in1 = v.a; in2 = v.b; cin = v.cin; sub = v.sub;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0; in1 = $urandom(); in2 = $urandom(); cin = ~v.cin; sub = ~v.sub;
    repeat (S - 2) @(negedge clk);
    check({v.name, "_early"}, out_valid, 1'b0);
    @(negedge clk);
    check({v.name, "_valid"}, out_valid, 1'b1);
    check({v.name, "_result"}, {ovf, cout, sum}, {v.e_ovf, v.e_cout, v.e_sum});
    @(negedge clk);
    check({v.name, "_one_cycle"}, out_valid, 1'b0);
  endtask

  initial begin
    rst_s = 1'b0;
    #23 rst_s = 1'b1;
  end

  initial begin
    vec_t        vecs [12];
    logic [33:0] exp_q [$];
    logic [31:0] bp_a, bp_b;
    logic        bp_c, bp_s;
    logic [33:0] e;
    int          idx, got, stale;

    vecs[0]  = '{32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0, "add_wrap"};
    vecs[1]  = '{32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h8000_0000, 1'b0, 1'b1, "ovf_pos"};
    vecs[2]  = '{32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1, "ovf_neg"};
    vecs[3]  = '{32'h0000_0007, 32'h0000_0005, 1'b1, 1'b1, 32'h0000_0002, 1'b1, 1'b0, "sub_7_5"};
    vecs[4]  = '{32'h0000_0005, 32'h0000_0007, 1'b1, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, "sub_5_7"};
    vecs[5]  = '{32'h8000_0000, 32'h0000_0001, 1'b1, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, "sub_min"};
    vecs[6]  = '{32'h0000_0001, 32'h0000_0002, 1'b1, 1'b0, 32'h0000_0004, 1'b0, 1'b0, "add_cin"};
    vecs[7]  = '{32'h00FF_FFFF, 32'h0000_0001, 1'b0, 1'b0, 32'h0100_0000, 1'b0, 1'b0, "chunk_ripple"};
    vecs[8]  = '{32'h0000_0000, 32'h0000_0000, 1'b0, 1'b1, 32'h0000_0000, 1'b1, 1'b0, "sub_zero"};
    vecs[9]  = '{32'h0000_0000, 32'h0000_0001, 1'b0, 1'b1, 32'hFFFF_FFFF, 1'b0, 1'b0, "sub_neg1"};
    vecs[10] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 32'h8000_0000, 1'b0, 1'b1, "sub_ovf"};
    vecs[11] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, "all_ones_cin"};

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in1 = '0; in2 = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("reset_outputs", {out_valid, ovf, cout, sum}, '0);
    check("reset_in_ready", in_ready, 1'b1);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) run_single(vecs[i]);

    // Ten back-to-back operations with the consumer stalled on cycles 3..8.
    idx = 0; got = 0;
    for (int c = 0; c < 40 && got < 10; c++) begin
      @(negedge clk);
      out_ready = !(c >= 3 && c <= 8);
      bp_a = 32'h1357_9BDF * 32'(idx + 1);
      bp_b = 32'hFEDC_BA98 ^ (32'h0101_0101 * 32'(idx));
      bp_s = idx[0];
      bp_c = idx[1];
      in_valid = (idx < 10);
      in1 = bp_a; in2 = bp_b; cin = bp_c; sub = bp_s;
      #1;
      if (c <= 12) check($sformatf("bp_in_ready_c%0d", c), in_ready, (c >= 4 && c <= 8) ? 1'b0 : 1'b1);
      if (c >= 4 && c <= 8) check($sformatf("bp_hold_c%0d", c), {out_valid, ovf, cout, sum}, {1'b1, exp_q[0]});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("bp_spurious", 1'b1, 1'b0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("bp_result_%0d", got), {ovf, cout, sum}, e);
        end
        got++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(model(bp_a, bp_b, bp_c, bp_s));
        idx++;
      end
    end
    check("bp_count", got, 10);
    @(negedge clk);
    in_valid = 1'b0;
    stale = 0;
    repeat (4) begin
      #1 if (out_valid) stale++;
      @(negedge clk);
    end
    check("bp_no_extra", stale, 0);

    // Three operations in flight, the oldest stalled at the output, then reset.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in1 = 32'h1234_5678 + 32'(i); in2 = 32'h1111_1111; cin = 1'b0; sub = 1'b0;
      in_valid = 1'b1;
      @(negedge clk);
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("rst_pre_valid", out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_async_outputs", {out_valid, ovf, cout, sum}, '0);
    check("rst_async_in_ready", in_ready, 1'b1);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (10) begin
      #1 if (out_valid) stale++;
      @(negedge clk);
    end
    check("rst_no_stale", stale, 0);

    for (int t = 0; t < 20000 && sweep_done < 3; t++) @(negedge clk);
    check("sweep_finished", sweep_done, 3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  for (genvar g = 0; g < 3; g++) begin : g_sweep
    localparam int SW = (g == 2) ? 64 : 16;
    localparam int SS = (g == 0) ? 1 : ((g == 1) ? 16 : 8);

    logic [SW-1:0] s_in1, s_in2, s_sum;
    logic          s_iv, s_ir, s_ov, s_or, s_cin, s_sub, s_cout, s_ovf;

    pipe_adder #(.WIDTH(SW), .STAGES(SS)) u_dut (
      .clk       (clk),
      .rst_n     (rst_s),
      .in_valid  (s_iv),
      .in_ready  (s_ir),
      .in1       (s_in1),
      .in2       (s_in2),
      .cin       (s_cin),
      .sub       (s_sub),
      .out_valid (s_ov),
      .out_ready (s_or),
      .sum       (s_sum),
      .cout      (s_cout),
      .ovf       (s_ovf)
    );

    function automatic logic [SW+1:0] smodel(input logic [SW-1:0] a, input logic [SW-1:0] b,
                                             input logic c, input logic sb);
      logic [SW-1:0] bb;
      logic [SW:0]   r;
      bb = sb ? ~b : b;
      r  = {1'b0, a} + {1'b0, bb} + (SW + 1)'(sb | c);
      return {(a[SW-1] == bb[SW-1]) && (r[SW-1] != a[SW-1]), r};
    endfunction

    initial begin
      logic [SW+1:0] exp_q [$];
      int            acc_q [$];
      logic [SW+1:0] e;
      int            sent, got, lat;
      sent = 0; got = 0;
      s_iv = 1'b0; s_or = 1'b0; s_in1 = '0; s_in2 = '0; s_cin = 1'b0; s_sub = 1'b0;
      repeat (4) @(negedge clk);
      for (int t = 0; t < 3000 && got < NOPS; t++) begin
        @(negedge clk);
        s_or  = (got < 10) ? 1'b1 : ($urandom_range(0, 3) != 0);
        s_iv  = (sent < 10) ? 1'b1 : (sent < NOPS && $urandom_range(0, 2) != 0);
        s_in1 = SW'({$urandom(), $urandom()});
        s_in2 = SW'({$urandom(), $urandom()});
        s_cin = 1'($urandom_range(0, 1));
        s_sub = 1'($urandom_range(0, 1));
        #1;
        if (s_ov && s_or) begin
          if (exp_q.size() == 0) begin
            check($sformatf("sweep%0d_spurious", g), 1'b1, 1'b0);
          end else begin
            e   = exp_q.pop_front();
            lat = cycle + 1 - acc_q.pop_front();
            check($sformatf("sweep%0d_result_%0d", g, got), {s_ovf, s_cout, s_sum}, e);
            if (got < 10) check($sformatf("sweep%0d_latency_%0d", g, got), lat, SS);
            else          check($sformatf("sweep%0d_latency_min_%0d", g, got), lat >= SS, 1'b1);
          end
          got++;
        end
        if (s_iv && s_ir) begin
          exp_q.push_back(smodel(s_in1, s_in2, s_cin, s_sub));
          acc_q.push_back(cycle + 1);
          sent++;
        end
      end
      s_iv = 1'b0;
      check($sformatf("sweep%0d_count", g), got, NOPS);
      sweep_done++;
    end
  end

endmodule
